// File: rtl/cnn_run_ctrl.sv
// cnn_run_ctrl: inference sequencer that streams one ROM image into the CNN core and maps the result to ASCII
// Ports: clk/reset_n (async active-low); i_start/i_sw start a run on image i_sw;
//   o_rom_addr/i_rom_data address a ROM with 1-cycle read latency; o_pix_valid/o_pix carry the pixel burst;
//   i_core_done/i_core_class return the class; o_out_valid/o_alpha deliver the letter; o_busy, o_err report status.
// Option: define CNN_RUN_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with an o_err pulse.
module cnn_run_ctrl #(
  parameter int IX        = 28,
  parameter int IY        = 28,
  parameter int I_F_BW    = 8,
  parameter int NUM_IMG   = 16,
  parameter int NUM_CLASS = 26,
  parameter int CLS_BW    = 5,
`ifdef CNN_RUN_TIMEOUT_EN
  parameter int TIMEOUT   = 4096,
`endif
  parameter int AW        = $clog2(NUM_IMG*IX*IY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [3:0]        i_sw,
  output logic              o_busy,
  output logic [AW-1:0]     o_rom_addr,
  input  logic [I_F_BW-1:0] i_rom_data,
  output logic              o_pix_valid,
  output logic [I_F_BW-1:0] o_pix,
  input  logic              i_core_done,
  input  logic [CLS_BW-1:0] i_core_class,
  output logic              o_out_valid,
  output logic [7:0]        o_alpha,
  output logic              o_err
);
  localparam int CW = $clog2(IX*IY);
  localparam logic [AW-1:0] PIX = AW'(IX*IY);
  localparam logic [CW-1:0] LAST = CW'(IX*IY-1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pv_q, err_q, err_d;
  logic [7:0]    alpha_q, alpha_d;
`ifdef CNN_RUN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    alpha_d = alpha_q;
`ifdef CNN_RUN_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: if (i_start) begin
        if (32'(i_sw) < NUM_IMG) begin
          state_d = LOAD;
          addr_d  = AW'(i_sw) * PIX;
          cnt_d   = '0;
        end else err_d = 1'b1;
      end
      LOAD: begin
        // Hold the address after the last pixel so base+cnt never steps past the image.
        addr_d  = (cnt_q == LAST) ? addr_q : addr_q + 1'b1;
        cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? WAIT : LOAD;
`ifdef CNN_RUN_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: if (i_core_done) begin
        state_d = DONE;
        alpha_d = (32'(i_core_class) < NUM_CLASS) ? 8'h61 + 8'(i_core_class) : 8'h3F;
      end
`ifdef CNN_RUN_TIMEOUT_EN
      else if (tmo_q == TW'(TIMEOUT-1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else tmo_d = tmo_q + 1'b1;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      alpha_q <= '0;
`ifdef CNN_RUN_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pv_q    <= (state_q == LOAD);
      err_q   <= err_d;
      alpha_q <= alpha_d;
`ifdef CNN_RUN_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
  // The ROM output register supplies the data; gating keeps o_pix at zero outside a burst and in reset.
  assign o_pix       = pv_q ? i_rom_data : '0;
  assign o_pix_valid = pv_q;
  assign o_rom_addr  = addr_q;
  assign o_busy      = (state_q == LOAD) || (state_q == WAIT);
  assign o_out_valid = (state_q == DONE);
  assign o_alpha     = alpha_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_cnn_run_ctrl.sv
// tb_cnn_run_ctrl: directed bench for cnn_run_ctrl with a synchronous ROM model
module tb_cnn_run_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_start = 1'b0;
  logic [3:0] i_sw = '0;
  logic i_core_done = 1'b0;
  logic [4:0] i_core_class = '0;
  logic [7:0] rom_q;
  logic o_busy, o_pix_valid, o_out_valid, o_err;
  logic [13:0] o_rom_addr;
  logic [7:0] o_pix, o_alpha;
  logic u8_busy, u8_pv, u8_ov, u8_err;
  logic [12:0] u8_addr;
  logic [7:0] u8_pix, u8_alpha;
  int pass_n = 0, total_n = 0, fail_n = 0;
  int bad_addr, bad_pv, bad_pix, bad_busy;
  always #5 clk = ~clk;
  function automatic logic [7:0] rom_f(int a);
    return 8'((a * 37 + (a >> 5)) ^ 8'h5A);
  endfunction
  always_ff @(posedge clk) rom_q <= rom_f(int'(o_rom_addr));
`ifdef CNN_RUN_TIMEOUT_EN
  cnn_run_ctrl #(.TIMEOUT(64)) dut (
`else
  cnn_run_ctrl dut (
`endif
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_sw(i_sw), .o_busy(o_busy),
    .o_rom_addr(o_rom_addr), .i_rom_data(rom_q), .o_pix_valid(o_pix_valid), .o_pix(o_pix),
    .i_core_done(i_core_done), .i_core_class(i_core_class), .o_out_valid(o_out_valid),
    .o_alpha(o_alpha), .o_err(o_err));
  cnn_run_ctrl #(.NUM_IMG(8)) u8 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_sw(i_sw), .o_busy(u8_busy),
    .o_rom_addr(u8_addr), .i_rom_data(rom_q), .o_pix_valid(u8_pv), .o_pix(u8_pix),
    .i_core_done(i_core_done), .i_core_class(i_core_class), .o_out_valid(u8_ov),
    .o_alpha(u8_alpha), .o_err(u8_err));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  // Start a run on sel at the next edge, then step through the burst checking addresses and beats.
  // On return we sit at the negedge of the first WAIT cycle (final beat on the bus).
  task automatic burst(int sel, bit pokes);
    int base;
    base = sel * 784;
    bad_addr = 0; bad_pv = 0; bad_pix = 0; bad_busy = 0;
    i_sw = 4'(sel); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 0; j <= 784; j++) begin
      if (j < 784 && int'(o_rom_addr) != base + j) bad_addr++;
      if (o_pix_valid !== (j >= 1)) bad_pv++;
      if (j >= 1 && o_pix !== rom_f(base + j - 1)) bad_pix++;
      if (o_busy !== 1'b1) bad_busy++;
      i_start = pokes && (j == 100 || j == 500);
      i_sw = pokes ? 4'd0 : i_sw;
      i_core_done = pokes && j == 200;
      i_core_class = 5'd3;
      if (j < 784) tick();
    end
    i_start = 1'b0;
    i_core_done = 1'b0;
    chk("addr_seq", bad_addr, 0);
    chk("pix_valid", bad_pv, 0);
    chk("pix_data", bad_pix, 0);
    chk("busy_run", bad_busy, 0);
  endtask
  initial begin
    tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_rom_addr, 0);
    chk("rst_pv_pix", {o_pix_valid, o_pix}, 0);
    chk("rst_ov_alpha_err", {o_out_valid, o_alpha, o_err}, 0);
    reset_n = 1'b1;
    tick();
    burst(4, 1'b1);
    chk("no_spurious_res", {o_out_valid, o_alpha}, 0);
    tick();
    chk("wait_busy", {o_busy, o_pix_valid}, 2'b10);
    i_core_done = 1'b1; i_core_class = 5'd7;
    tick();
    i_core_done = 1'b0;
    chk("res_valid", {o_out_valid, o_busy}, 2'b10);
    chk("res_alpha_h", o_alpha, 8'h68);
    i_core_done = 1'b1; i_core_class = 5'd2;
    tick();
    i_core_done = 1'b0;
    chk("res_one_cycle", {o_out_valid, o_busy}, 2'b00);
    tick();
    chk("alpha_held", {o_out_valid, o_alpha}, {1'b0, 8'h68});
    burst(15, 1'b0);
    i_core_done = 1'b1; i_core_class = 5'd30;
    tick();
    i_core_done = 1'b0;
    chk("res_bad_class", {o_out_valid, o_alpha}, {1'b1, 8'h3F});
    tick();
    chk("res_clear", {o_out_valid, o_busy}, 2'b00);
    i_sw = 4'd15; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("err8_pulse", {u8_err, u8_busy, u8_addr == 13'd0 || 1'b1}, 3'b101);
    chk("err8_no_load", u8_pv, 0);
    tick();
    chk("err8_one_cycle", {u8_err, u8_busy}, 2'b00);
    chk("main_accepts15", {o_busy, o_rom_addr}, {1'b1, 14'd11761});
    // Let the main instance finish this run before the reset test.
    for (int j = 0; j < 784; j++) tick();
    i_core_done = 1'b1; i_core_class = 5'd0;
    tick();
    i_core_done = 1'b0;
    chk("res_a", {o_out_valid, o_alpha}, {1'b1, 8'h61});
    tick();
    i_sw = 4'd9; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < 301; j++) tick();
    chk("mid_load", {o_busy, o_pix_valid, o_rom_addr}, {2'b11, 14'(9 * 784 + 301)});
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {o_busy, o_pix_valid, o_pix, o_err}, 0);
    chk("async_rst_addr", o_rom_addr, 0);
    chk("async_rst_res", {o_out_valid, o_alpha}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    burst(0, 1'b0);
`ifdef CNN_RUN_TIMEOUT_EN
    for (int j = 0; j < 63; j++) tick();
    chk("pre_timeout", {o_busy, o_err}, 2'b10);
    tick();
    chk("timeout_err", {o_busy, o_err, o_out_valid}, 3'b010);
    chk("timeout_alpha", o_alpha, 0);
    tick();
    chk("timeout_idle", {o_busy, o_err}, 2'b00);
`else
    for (int j = 0; j < 10000; j++) tick();
    chk("no_timeout", {o_busy, o_err, o_out_valid}, 3'b100);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
